prog_loader: RTL

Boot-time program loader that sits directly upstream of the MIPS core and its instruction memory. It accepts a framed byte stream over a valid/ready interface, packs the bytes big-endian into 32-bit instructions, and writes them to the instruction memory write port at word-aligned byte addresses starting at 0. It verifies a trailing XOR checksum and holds the core in reset (`cpu_rst`) until a good image has been loaded.

---
 rtl/mips_pkg.sv | 18 +
 rtl/prog_loader.sv | 124 ++++++++++++
 2 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS-system types and constants.
// Also holds the boot loader's state encoding and frame constants.
package mips_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE,
    ERROR
  } loader_state_t;

  localparam int LOADER_LEN_WIDTH = 16;
  localparam int BYTES_PER_WORD   = 4;

endpackage

// File: rtl/prog_loader.sv
// Boot-time program loader: framed byte stream -> big-endian 32-bit words
// written to instruction memory; holds the core in reset until a good image lands.
//
//   state  | meaning
//   IDLE   | after reset, waiting for start
//   LEN_HI | expecting word-count high byte
//   LEN_LO | expecting word-count low byte, length validated here
//   DATA   | packing data bytes into words, writing each completed word
//   CSUM   | expecting the XOR checksum byte
//   DONE   | image accepted, core released from reset
//   ERROR  | bad length or checksum, core held in reset
module prog_loader
  import mips_pkg::*;
#(
  parameter int ADDR_SIZE   = 1024,
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   rx_ready,
  output logic                   imem_we,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  output logic [INSTR_WIDTH-1:0] imem_wdata,
  output logic                   cpu_rst,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int IDX_W = $clog2(ADDR_SIZE) + 1;
  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  loader_state_t               state;
  logic [IDX_W-1:0]            word_idx;
  logic [IDX_W-1:0]            word_len;
  logic [CNT_W-1:0]            byte_cnt;
  logic [7:0]                  len_hi;
  logic [7:0]                  csum;
  logic [INSTR_WIDTH-9:0]      word_buf;

  logic                        xfer;
  logic [LOADER_LEN_WIDTH-1:0] len_rx;
  logic                        len_bad;
  logic [IDX_W-1:0]            idx_nxt;

  assign rx_ready = (state == LEN_HI) || (state == LEN_LO) ||
                    (state == DATA)   || (state == CSUM);
  assign busy     = rx_ready;
  assign cpu_rst  = (state != DONE);
  assign done     = (state == DONE);
  assign error    = (state == ERROR);

  assign xfer     = rx_valid && rx_ready;
  assign len_rx   = {len_hi, rx_data};
  assign len_bad  = (len_rx == '0) || (32'(len_rx) > 32'(ADDR_SIZE));
  assign idx_nxt  = word_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      word_idx   <= '0;
      word_len   <= '0;
      byte_cnt   <= '0;
      len_hi     <= '0;
      csum       <= '0;
      word_buf   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state    <= LEN_HI;
            word_idx <= '0;
            byte_cnt <= '0;
            csum     <= '0;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            len_hi <= rx_data;
            state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            word_len <= IDX_W'(len_rx);
            state    <= len_bad ? ERROR : DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            csum     <= csum ^ rx_data;
            byte_cnt <= byte_cnt + 1'b1;
            // First three bytes are buffered; the fourth completes and writes the word.
            case (byte_cnt)
              2'd0: word_buf[23:16] <= rx_data;
              2'd1: word_buf[15:8]  <= rx_data;
              2'd2: word_buf[7:0]   <= rx_data;
              default: begin
                imem_we    <= 1'b1;
                imem_addr  <= ADDR_WIDTH'(word_idx) << 2;
                imem_wdata <= {word_buf, rx_data};
                word_idx   <= idx_nxt;
                if (idx_nxt == word_len) state <= CSUM;
              end
            endcase
          end
        end
        CSUM: begin
          if (xfer) state <= (rx_data == csum) ? DONE : ERROR;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
